rf_write_arbiter: RTL and testbench

Round-robin arbiter sharing the register file's single write port (we3/wa3/wd3) between two requesters, e.g. ALU writeback (port 0) and load/immediate unit (port 1). One write per cycle is granted and registered onto the write port. Writes targeting r0 are accepted and discarded. A saturating counter records contention for debug.

---
 rtl/rf_write_arbiter.sv | 96 +++++++++
 tb/tb_rf_write_arbiter.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: shares the register file's single write port between two requesters.
// The arbiter grants one write per cycle: combinationally, with round-robin priority under
// contention. The granted write is registered onto we3/wa3/wd3, and writes to r0 are dropped.
// A saturating counter records how many cycles saw contention.

module rf_write_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             req0,
    input  logic [2:0]       wa0,
    input  logic [WIDTH-1:0] wd0,
    output logic             gnt0,
    input  logic             req1,
    input  logic [2:0]       wa1,
    input  logic [WIDTH-1:0] wd1,
    output logic             gnt1,
    output logic             we3,
    output logic [2:0]       wa3,
    output logic [WIDTH-1:0] wd3,
    output logic [7:0]       conflicts
);

    // prio_q: 0 favours port 0 when both request, 1 favours port 1
    logic             prio_q,      prio_d;
    logic             we3_q,       we3_d;
    logic [2:0]       wa3_q,       wa3_d;
    logic [WIDTH-1:0] wd3_q,       wd3_d;
    logic [7:0]       conflicts_q, conflicts_d;
    logic             contend;

    assign contend = req0 && req1 && !stall;

    // Grant selection: stall or reset blocks both grants; otherwise a lone requester wins and prio breaks ties
    always_comb begin
        // NOTE: default every output first so no path leaves it unassigned and infers a latch.
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (rst_n && !stall) begin
            if (req0 && (!req1 || !prio_q)) begin
                gnt0 = 1'b1;
            end else if (req1) begin
                gnt1 = 1'b1;
            end
        end
    end

    // Next-state logic for the priority pointer, write port and contention counter
    always_comb begin
        prio_d      = prio_q;
        we3_d       = 1'b0;
        wa3_d       = wa3_q;
        wd3_d       = wd3_q;
        conflicts_d = conflicts_q;
        if (gnt0) begin
            prio_d = 1'b1;
            we3_d  = (wa0 != 3'd0);
            wa3_d  = wa0;
            wd3_d  = wd0;
        end else if (gnt1) begin
            prio_d = 1'b0;
            we3_d  = (wa1 != 3'd0);
            wa3_d  = wa1;
            wd3_d  = wd1;
        end
        if (contend && (conflicts_q != 8'hFF)) begin
            conflicts_d = conflicts_q + 8'd1;
        end
    end

    // State registers; reset clears everything immediately, including any in-flight write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio_q      <= 1'b0;
            we3_q       <= 1'b0;
            wa3_q       <= 3'd0;
            wd3_q       <= '0;
            conflicts_q <= 8'd0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the pre-edge values.
            prio_q      <= prio_d;
            we3_q       <= we3_d;
            wa3_q       <= wa3_d;
            wd3_q       <= wd3_d;
            conflicts_q <= conflicts_d;
        end
    end

    assign we3       = we3_q;
    assign wa3       = wa3_q;
    assign wd3       = wd3_q;
    assign conflicts = conflicts_q;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed testbench for rf_write_arbiter.
// Inputs change on the falling edge; outputs are sampled 1 ns later, well away from the rising edge.

module tb_rf_write_arbiter;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic             stall;
    logic             req0, req1;
    logic [2:0]       wa0, wa1;
    logic [WIDTH-1:0] wd0, wd1;
    logic             gnt0, gnt1;
    logic             we3;
    logic [2:0]       wa3;
    logic [WIDTH-1:0] wd3;
    logic [7:0]       conflicts;

    int n_checks = 0;
    int n_fail   = 0;

    rf_write_arbiter #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .stall     (stall),
        .req0      (req0),
        .wa0       (wa0),
        .wd0       (wd0),
        .gnt0      (gnt0),
        .req1      (req1),
        .wa1       (wa1),
        .wd1       (wd1),
        .gnt1      (gnt1),
        .we3       (we3),
        .wa3       (wa3),
        .wd3       (wd3),
        .conflicts (conflicts)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Advance to the next falling edge (the input-drive point)
    task automatic to_negedge();
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; stall = 1'b0;
        req0 = 1'b1; wa0 = 3'd5; wd0 = 8'h3C;
        req1 = 1'b0; wa1 = 3'd0; wd1 = 8'h00;

        // Reset holds everything at zero and masks the pending request
        repeat (3) to_negedge();
        #1;
        check("rst_gnt0", gnt0, 1'b0);
        check("rst_gnt1", gnt1, 1'b0);
        check("rst_we3", we3, 1'b0);
        check("rst_wa3", wa3, 3'd0);
        check("rst_wd3", wd3, 8'h00);
        check("rst_conflicts", conflicts, 8'd0);

        // Release: grant is visible in the same cycle, the write one cycle later
        to_negedge();
        rst_n = 1'b1;
        #1;
        check("rel_gnt0", gnt0, 1'b1);
        to_negedge();
        req0 = 1'b0;
        #1;
        check("rel_we3", we3, 1'b1);
        check("rel_wa3", wa3, 3'd5);
        check("rel_wd3", wd3, 8'h3C);

        // Single requester (prio now favours port 1, but a lone port 0 still wins)
        to_negedge();
        req0 = 1'b1; wa0 = 3'd3; wd0 = 8'hA5;
        #1;
        check("single_gnt0", gnt0, 1'b1);
        check("single_gnt1", gnt1, 1'b0);
        to_negedge();
        req0 = 1'b0;
        #1;
        check("single_we3", we3, 1'b1);
        check("single_wa3", wa3, 3'd3);
        check("single_wd3", wd3, 8'hA5);
        check("single_gnt0_off", gnt0, 1'b0);
        to_negedge();
        #1;
        check("single_we3_off", we3, 1'b0);
        check("single_wa3_hold", wa3, 3'd3);

        // Contention after a fresh reset: grants alternate 0,1,0,1
        to_negedge();
        rst_n = 1'b0;
        #1;
        check("cont_rst_conflicts", conflicts, 8'd0);
        to_negedge();
        rst_n = 1'b1;
        req0 = 1'b1; wa0 = 3'd1; wd0 = 8'h11;
        req1 = 1'b1; wa1 = 3'd2; wd1 = 8'h22;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) to_negedge();
            #1;
            check($sformatf("cont_gnt0_%0d", k), gnt0, (k % 2 == 0));
            check($sformatf("cont_gnt1_%0d", k), gnt1, (k % 2 == 1));
            if (k > 0) begin
                check($sformatf("cont_we3_%0d", k), we3, 1'b1);
                check($sformatf("cont_wa3_%0d", k), wa3, (k % 2 == 1) ? 3'd1 : 3'd2);
            end
        end
        to_negedge();
        req0 = 1'b0; req1 = 1'b0;
        #1;
        check("cont_wa3_last", wa3, 3'd2);
        check("cont_wd3_last", wd3, 8'h22);
        check("cont_conflicts", conflicts, 8'd4);

        // Port 0 transfer moves prio to port 1, then an r0 write from port 1 moves it back to port 0
        to_negedge();
        req0 = 1'b1; wa0 = 3'd4; wd0 = 8'h44;
        #1;
        check("pre_r0_gnt0", gnt0, 1'b1);
        to_negedge();
        req0 = 1'b0;
        req1 = 1'b1; wa1 = 3'd0; wd1 = 8'hFF;
        #1;
        check("r0_gnt1", gnt1, 1'b1);
        check("r0_gnt0", gnt0, 1'b0);
        check("pre_r0_wa3", wa3, 3'd4);
        to_negedge();
        req1 = 1'b0;
        #1;
        check("r0_we3", we3, 1'b0);
        check("r0_wd3", wd3, 8'hFF);

        // Stall: no grants, no writes, counter frozen; afterwards prio (port 0) wins
        to_negedge();
        stall = 1'b1;
        req0 = 1'b1; wa0 = 3'd6; wd0 = 8'h66;
        req1 = 1'b1; wa1 = 3'd7; wd1 = 8'h77;
        for (int k = 0; k < 3; k++) begin
            if (k > 0) to_negedge();
            #1;
            check($sformatf("stall_gnt0_%0d", k), gnt0, 1'b0);
            check($sformatf("stall_gnt1_%0d", k), gnt1, 1'b0);
            check($sformatf("stall_we3_%0d", k), we3, 1'b0);
            check($sformatf("stall_conf_%0d", k), conflicts, 8'd4);
        end
        to_negedge();
        stall = 1'b0;
        #1;
        check("unstall_gnt0", gnt0, 1'b1);
        check("unstall_gnt1", gnt1, 1'b0);
        check("unstall_conf", conflicts, 8'd4);
        to_negedge();
        #1;
        check("unstall_gnt1_next", gnt1, 1'b1);
        check("unstall_wa3", wa3, 3'd6);
        check("unstall_conf_next", conflicts, 8'd5);
        to_negedge();
        #1;
        check("unstall_wa3_next", wa3, 3'd7);
        check("unstall_wd3_next", wd3, 8'h77);
        check("unstall_conf_2", conflicts, 8'd6);

        // Saturation: long contention pins the counter at 255
        repeat (300) to_negedge();
        #1;
        check("sat_conflicts", conflicts, 8'd255);
        to_negedge();
        #1;
        check("sat_hold", conflicts, 8'd255);

        // Asynchronous reset mid-sequence clears state immediately
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_conflicts", conflicts, 8'd0);
        check("mid_rst_we3", we3, 1'b0);
        check("mid_rst_gnt0", gnt0, 1'b0);
        check("mid_rst_gnt1", gnt1, 1'b0);
        to_negedge();
        rst_n = 1'b1;
        #1;
        check("post_rst_gnt0", gnt0, 1'b1);
        check("post_rst_gnt1", gnt1, 1'b0);
        to_negedge();
        req0 = 1'b0; req1 = 1'b0;
        #1;
        check("post_rst_wa3", wa3, 3'd6);
        check("post_rst_conf", conflicts, 8'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
